// File: rtl/slot_pkg.sv
// -----------------------------------------------------------------------------
// slot_pkg
// Shared definitions for the slot machine button front end: the per-channel
// debounce FSM state type and the channel index map used to pack the four
// buttons into a bus ordered {stop[2:0], start}.
// -----------------------------------------------------------------------------
package slot_pkg;

    // Per-channel debounce state.
    //   ARM     : waiting to see the button released after reset
    //   IDLE    : released, watching for a press
    //   PRESSED : accepted press, watching for a release
    typedef enum logic [1:0] {
        ARM     = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2
    } chan_state_e;

    // Channel positions in the packed button bus.
    localparam int CH_START  = 0;
    localparam int CH_LEFT   = 1;
    localparam int CH_MIDDLE = 2;
    localparam int CH_RIGHT  = 3;
    localparam int NUM_CH    = 4;

endpackage

// File: rtl/slot_debounce_channel.sv
// -----------------------------------------------------------------------------
// slot_debounce_channel
// One button channel: 2-flop synchroniser, polarity normalisation, debounce
// FSM with agreement counter, and a registered single-cycle press pulse.
//
// Parameters
//   DEBOUNCE_TICKS    : consecutive agreeing ticks needed to accept a change
//   BUTTON_ACTIVE_LOW : 1 = raw 0 means pressed
// Ports
//   clock      in  system clock
//   reset      in  asynchronous active-low reset
//   tick       in  debounce sample strobe from the shared prescaler
//   button_raw in  raw button level, asynchronous to clock
//   pulse      out one-clock pulse on an accepted press (registered)
//   held       out debounced pressed level (registered)
// -----------------------------------------------------------------------------
module slot_debounce_channel
    import slot_pkg::*;
#(
    parameter int DEBOUNCE_TICKS    = 10,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic button_raw,
    output logic pulse,
    output logic held
);

    localparam int            CW             = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST       = CW'(DEBOUNCE_TICKS - 1);
    localparam logic          RELEASED_LEVEL = BUTTON_ACTIVE_LOW;

    logic          sync_a;
    logic          sync_b;
    logic          pressed;
    logic          toward;
    chan_state_e   state;
    chan_state_e   state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          fire;
    logic          held_next;

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= RELEASED_LEVEL;
            sync_b <= RELEASED_LEVEL;
        end else begin
            sync_a <= button_raw;
            sync_b <= sync_a;
        end
    end

    assign pressed = BUTTON_ACTIVE_LOW ? ~sync_b : sync_b;

    // State and agreement counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ARM;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A tick "agrees" when the sampled level points away from the current
    // state: released for ARM/PRESSED, pressed for IDLE. Any other tick
    // restarts the count.
    always_comb begin
        toward = (state == IDLE) ? pressed : ~pressed;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (tick) begin
            if (toward) begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    case (state)
                        ARM:     state_next = IDLE;
                        IDLE:    state_next = PRESSED;
                        PRESSED: state_next = IDLE;
                        default: state_next = ARM;
                    endcase
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end else begin
                cnt_next = '0;
            end
        end
    end

    // Output decode. Only IDLE->PRESSED fires; ARM->IDLE and release are silent.
    always_comb begin
        fire      = (state == IDLE) && (state_next == PRESSED);
        held_next = (state_next == PRESSED);
    end

    // Registered outputs, so the pulse lands on the same edge as the transition.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pulse <= 1'b0;
            held  <= 1'b0;
        end else begin
            pulse <= fire;
            held  <= held_next;
        end
    end

endmodule

// File: rtl/slot_button_conditioner.sv
// -----------------------------------------------------------------------------
// slot_button_conditioner
// Front-end input stage for the slot machine: synchronises and debounces the
// start and three reel-stop buttons and emits clean single-cycle press pulses.
// A shared prescaler sets the debounce sample rate for all four channels.
//
// Parameters
//   CLK_DIV           : clocks per debounce sample tick (>=1)
//   DEBOUNCE_TICKS    : consecutive agreeing ticks to accept a change (>=1)
//   BUTTON_ACTIVE_LOW : 1 = raw 0 means pressed
// Ports
//   clock     in  system clock
//   reset     in  asynchronous active-low reset
//   start_raw in  raw start button
//   stop_raw  in  raw stop buttons [2:0] = {right, middle, left}
//   start     out one-clock start press pulse
//   stop      out one-clock stop press pulses, one per reel
//   held      out debounced pressed levels, {stop[2:0], start}
// -----------------------------------------------------------------------------
module slot_button_conditioner
    import slot_pkg::*;
#(
    parameter int CLK_DIV           = 50000,
    parameter int DEBOUNCE_TICKS    = 10,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_raw,
    input  logic [2:0] stop_raw,
    output logic       start,
    output logic [2:0] stop,
    output logic [3:0] held
);

    logic                tick;
    logic [NUM_CH-1:0]   raw_bus;
    logic [NUM_CH-1:0]   pulse_bus;

    // Prescaler: counts 0..CLK_DIV-1; tick on the last count.
    generate
        if (CLK_DIV <= 1) begin : g_no_div
            assign tick = 1'b1;
        end else begin : g_div
            localparam int            PW    = $clog2(CLK_DIV);
            localparam logic [PW-1:0] PLAST = PW'(CLK_DIV - 1);

            logic [PW-1:0] count;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    count <= '0;
                end else if (count == PLAST) begin
                    count <= '0;
                end else begin
                    count <= count + PW'(1);
                end
            end

            assign tick = (count == PLAST);
        end
    endgenerate

    assign raw_bus = {stop_raw, start_raw};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        slot_debounce_channel #(
            .DEBOUNCE_TICKS   (DEBOUNCE_TICKS),
            .BUTTON_ACTIVE_LOW(BUTTON_ACTIVE_LOW)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .tick      (tick),
            .button_raw(raw_bus[i]),
            .pulse     (pulse_bus[i]),
            .held      (held[i])
        );
    end

    assign start = pulse_bus[CH_START];
    assign stop  = pulse_bus[CH_RIGHT:CH_LEFT];

endmodule

// File: doc/slot_button_conditioner.md
# slot_button_conditioner

Front-end input stage for the slot machine. Takes the four raw push-button inputs (one start, three reel stops), synchronises and debounces each, and emits clean single-cycle press pulses on `start` and `stop[2:0]`, consumed directly by the slot body. Each channel runs its own state machine. A shared prescaler sets the debounce sample rate. A button held through reset is ignored until it has been seen released.

## Interface

Parameters:
- `CLK_DIV`, default 50000: clocks per debounce sample tick; ≥1.
- `DEBOUNCE_TICKS`, default 10: consecutive agreeing ticks needed to accept a level change; ≥1.
- `BUTTON_ACTIVE_LOW`, default 1: 1 means a raw input of 0 is "pressed".

Ports:
- `clock`, in, 1: system clock. One clock domain.
- `reset`, in, 1: asynchronous, active-low reset.
- `start_raw`, in, 1: raw start button, asynchronous to `clock`.
- `stop_raw`, in, 3: raw stop buttons (left, middle, right), asynchronous.
- `start`, out, 1: one-clock press pulse.
- `stop`, out, 3: one-clock press pulses, one per reel.
- `held`, out, 4: debounced pressed level, bit order {stop[2:0], start}.

## Operation

- Prescaler counts 0..CLK_DIV-1 and wraps.
  - `tick` = (count == CLK_DIV-1).
  - With CLK_DIV=1, `tick` is constant 1.
- Each raw input goes through a 2-flop synchroniser, then is normalised to an active-high `pressed` level using `BUTTON_ACTIVE_LOW`.
- Each channel has an FSM with states ARM, IDLE, PRESSED and an agreement counter `cnt` of width $clog2(DEBOUNCE_TICKS+1).
- ARM (entered on reset):
  - On a tick with `pressed`=0: cnt++. When cnt reaches DEBOUNCE_TICKS, go to IDLE and set cnt=0.
  - On a tick with `pressed`=1: cnt=0.
  - No pulse is ever produced from ARM.
- IDLE:
  - On a tick with `pressed`=1: cnt++. When cnt reaches DEBOUNCE_TICKS, go to PRESSED, set cnt=0, and fire a pulse.
  - On a tick with `pressed`=0: cnt=0.
- PRESSED:
  - On a tick with `pressed`=0: cnt++. When cnt reaches DEBOUNCE_TICKS, go to IDLE and set cnt=0. No pulse on release.
  - On a tick with `pressed`=1: cnt=0.
- Off-tick cycles: cnt and state hold.
- `held[i]` = 1 exactly when channel i is in PRESSED.
- Channels are fully independent. Simultaneous presses produce same-cycle pulses; there is no priority or masking.
- Interpreting start/stop meaning (for example, a stop while idle) is the slot body's job, not this block's.

## Timing

- All outputs are registered.
- Reset values:
  - `start`=0, `stop`=0, `held`=0.
  - All FSMs in ARM, cnt=0, prescaler=0.
  - Synchroniser flops hold the released level.
- The pulse register is set on the same edge that moves IDLE→PRESSED. The pulse is high for exactly one cycle and cleared on the next edge.
- Latency from a clean raw edge to the pulse: 2 sync cycles, plus up to DEBOUNCE_TICKS×CLK_DIV cycles, plus the register stage. Maximum is 3 + DEBOUNCE_TICKS×CLK_DIV cycles.
- Any disagreeing tick restarts the count. Bounces shorter than DEBOUNCE_TICKS ticks produce no pulse and no `held` change.
- Reset asserted mid-count or mid-press:
  - Immediate return to reset values.
  - Any pulse in flight is dropped.
  - A button still held after reset release gives no pulse until it is released for DEBOUNCE_TICKS ticks and then re-pressed.
- A button held indefinitely gives exactly one pulse. There is no auto-repeat.

## Structure

- Shared package `slot_pkg`:
  - Channel FSM state enum (ARM, IDLE, PRESSED).
  - Channel index constants CH_START=0, CH_LEFT=1, CH_MIDDLE=2, CH_RIGHT=3.
- Sub-module `slot_debounce_channel` contains synchroniser, normalisation, FSM, cnt and pulse register. It takes `tick` and DEBOUNCE_TICKS/BUTTON_ACTIVE_LOW as inputs.
- Top level holds the prescaler and instantiates four channels.
- `held` is for LED/diagnostic use; the slot body needs only the pulses.

## Test plan

All scenarios use CLK_DIV=4, DEBOUNCE_TICKS=3, BUTTON_ACTIVE_LOW=1.

- **Post-reset arming:** raw inputs all 1 (released) from reset release → no pulses. Every channel reaches IDLE by cycle 15.
- **Clean press:** `stop_raw[1]` driven 0 after arming, held 40 cycles → exactly one `stop[1]` pulse within 15 cycles of the edge. `held[2]`=1 until release + ≤15 cycles. No pulse on release.
- **Bounce:** `start_raw` toggles every 5 cycles for 60 cycles, then settles at 0 → no pulse during bouncing. Exactly one `start` pulse within 15 cycles of settling.
- **Simultaneous:** `stop_raw[0]` and `stop_raw[2]` fall on the same cycle → `stop[0]` and `stop[2]` pulse in the same cycle. `stop[1]` and `start` stay 0.
- **Held through reset:** `start_raw`=0 across reset release for 100 cycles → no pulse. Then release for 20 cycles and re-press → one pulse.
- **Reset mid-press:** reset asserted 2 ticks into a `stop[0]` press count → outputs go to 0 immediately. No pulse follows reset release while the button stays held.
